// File: rtl/pipe_mips32_pkg.sv
// Shared definitions for the five-stage MIPS32-subset pipeline: opcodes, field
// positions, instruction classes and the pipeline-register layouts.
package pipe_mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP
    } instr_class_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        logic         valid;
        instr_class_e cls;
        logic [5:0]   op;
        alu_op_e      alu_op;
        logic         we;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   dest;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  imm;
        logic [31:0]  npc;
    } id_ex_t;

    typedef struct packed {
        logic         valid;
        instr_class_e cls;
        logic         we;
        logic [4:0]   dest;
        logic [31:0]  alu;
        logic [31:0]  store;
    } ex_mem_t;

    typedef struct packed {
        logic         valid;
        instr_class_e cls;
        logic         we;
        logic [4:0]   dest;
        logic [31:0]  result;
    } mem_wb_t;

    function automatic instr_class_e decode_class(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

    // Loads and stores use the adder for their effective address.
    function automatic alu_op_e decode_alu_op(input logic [5:0] op);
        case (op)
            OP_SUB, OP_SUBI: return ALU_SUB;
            OP_AND:          return ALU_AND;
            OP_OR:           return ALU_OR;
            OP_SLT, OP_SLTI: return ALU_SLT;
            OP_MUL:          return ALU_MUL;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/pipe_mips32_alu.sv
// Combinational 32-bit ALU: wrap-around add/sub/mul, bitwise ops, signed set-less-than.
module pipe_mips32_alu
    import pipe_mips32_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
            ALU_MUL: result = a * b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset pipeline with unified memory, EX-stage branch
// resolution, EX operand forwarding and halt-on-retire.
module pipe_mips32
    import pipe_mips32_pkg::*;
#(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [31:0] Reg [0:31];
    logic [31:0] mem [0:MEM_DEPTH-1];

    logic [31:0] PC, pc_d;
    logic        HALTED, halted_d;
    logic        TAKEN_BRANCH, taken_branch_d;
    logic        fetch_stop_q, fetch_stop_d;

    if_id_t  if_id_q,  if_id_d;
    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    // Write-back
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    assign wb_we   = mem_wb_q.valid && mem_wb_q.we && !HALTED;
    assign wb_dest = mem_wb_q.dest;
    assign wb_data = mem_wb_q.result;

    // Decode
    logic [5:0]   id_op;
    logic [4:0]   id_rs, id_rt, id_rd, id_dest;
    logic [31:0]  id_imm, id_a, id_b;
    instr_class_e id_cls;
    logic         id_we;

    assign id_op   = if_id_q.ir[OP_HI:OP_LO];
    assign id_rs   = if_id_q.ir[RS_HI:RS_LO];
    assign id_rt   = if_id_q.ir[RT_HI:RT_LO];
    assign id_rd   = if_id_q.ir[RD_HI:RD_LO];
    assign id_imm  = {{16{if_id_q.ir[IMM_HI]}}, if_id_q.ir[IMM_HI:IMM_LO]};
    assign id_cls  = decode_class(id_op);
    assign id_dest = (id_cls == RR_ALU) ? id_rd : id_rt;
    assign id_we   = if_id_q.valid && (id_dest != 5'd0)
                     && (id_cls == RR_ALU || id_cls == RM_ALU || id_cls == LOAD);

    // The register file is write-before-read, so the WB value is bypassed into ID.
    always_comb begin
        id_a = Reg[id_rs];
        id_b = Reg[id_rt];
        if (wb_we && wb_dest == id_rs) id_a = wb_data;
        if (wb_we && wb_dest == id_rt) id_b = wb_data;
        if (id_rs == 5'd0) id_a = '0;
        if (id_rt == 5'd0) id_b = '0;
    end

    // Execute: the youngest producer (EX/MEM) overrides MEM/WB; loads in EX/MEM have no data yet.
    logic [31:0] ex_a, ex_b, alu_b, alu_y, branch_target;
    logic        branch_taken;

    always_comb begin
        ex_a = id_ex_q.a;
        ex_b = id_ex_q.b;
        if (mem_wb_q.valid && mem_wb_q.we && mem_wb_q.dest == id_ex_q.rs) ex_a = mem_wb_q.result;
        if (mem_wb_q.valid && mem_wb_q.we && mem_wb_q.dest == id_ex_q.rt) ex_b = mem_wb_q.result;
        if (ex_mem_q.valid && ex_mem_q.we && ex_mem_q.cls != LOAD && ex_mem_q.dest == id_ex_q.rs)
            ex_a = ex_mem_q.alu;
        if (ex_mem_q.valid && ex_mem_q.we && ex_mem_q.cls != LOAD && ex_mem_q.dest == id_ex_q.rt)
            ex_b = ex_mem_q.alu;
    end

    assign alu_b = (id_ex_q.cls == RR_ALU) ? ex_b : id_ex_q.imm;

    pipe_mips32_alu u_alu (
        .op     (id_ex_q.alu_op),
        .a      (ex_a),
        .b      (alu_b),
        .result (alu_y)
    );

    assign branch_target = id_ex_q.npc + id_ex_q.imm;
    assign branch_taken  = id_ex_q.valid && (id_ex_q.cls == BRANCH)
                           && ((id_ex_q.op == OP_BEQZ) ? (ex_a == 32'd0) : (ex_a != 32'd0));

    // Memory access and fetch share the unified array
    logic [AW-1:0] fetch_addr, mem_addr;
    logic [31:0]   load_data;
    logic          mem_we;

    assign fetch_addr = AW'(PC % 32'(MEM_DEPTH));
    assign mem_addr   = AW'(ex_mem_q.alu % 32'(MEM_DEPTH));
    assign load_data  = mem[mem_addr];
    assign mem_we     = ex_mem_q.valid && (ex_mem_q.cls == STORE) && !HALTED;

    logic hlt_in_id;
    assign hlt_in_id = if_id_q.valid && (id_cls == HALT);

    always_comb begin
        pc_d           = PC;
        if_id_d        = '0;
        id_ex_d        = '0;
        fetch_stop_d   = fetch_stop_q;
        taken_branch_d = branch_taken;

        // A taken branch squashes both younger stages, including a HLT sitting in ID.
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (!(fetch_stop_q || hlt_in_id)) begin
            pc_d          = PC + 32'd1;
            if_id_d.valid = 1'b1;
            if_id_d.ir    = mem[fetch_addr];
            if_id_d.npc   = PC + 32'd1;
        end

        if (!branch_taken) begin
            fetch_stop_d   = fetch_stop_q | hlt_in_id;
            id_ex_d.valid  = if_id_q.valid;
            id_ex_d.cls    = id_cls;
            id_ex_d.op     = id_op;
            id_ex_d.alu_op = decode_alu_op(id_op);
            id_ex_d.we     = id_we;
            id_ex_d.rs     = id_rs;
            id_ex_d.rt     = id_rt;
            id_ex_d.dest   = id_dest;
            id_ex_d.a      = id_a;
            id_ex_d.b      = id_b;
            id_ex_d.imm    = id_imm;
            id_ex_d.npc    = if_id_q.npc;
        end

        ex_mem_d.valid = id_ex_q.valid;
        ex_mem_d.cls   = id_ex_q.cls;
        ex_mem_d.we    = id_ex_q.valid && id_ex_q.we;
        ex_mem_d.dest  = id_ex_q.dest;
        ex_mem_d.alu   = alu_y;
        ex_mem_d.store = ex_b;

        mem_wb_d.valid  = ex_mem_q.valid;
        mem_wb_d.cls    = ex_mem_q.cls;
        mem_wb_d.we     = ex_mem_q.valid && ex_mem_q.we;
        mem_wb_d.dest   = ex_mem_q.dest;
        mem_wb_d.result = (ex_mem_q.cls == LOAD) ? load_data : ex_mem_q.alu;

        halted_d = HALTED | (mem_wb_q.valid && mem_wb_q.cls == HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC           <= RESET_PC;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            fetch_stop_q <= 1'b0;
            if_id_q      <= '0;
            id_ex_q      <= '0;
            ex_mem_q     <= '0;
            mem_wb_q     <= '0;
        end else if (!HALTED) begin
            PC           <= pc_d;
            HALTED       <= halted_d;
            TAKEN_BRANCH <= taken_branch_d;
            fetch_stop_q <= fetch_stop_d;
            if_id_q      <= if_id_d;
            id_ex_q      <= id_ex_d;
            ex_mem_q     <= ex_mem_d;
            mem_wb_q     <= mem_wb_d;
        end
    end

    // Architectural storage is never cleared; writes are suppressed on a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && wb_we) Reg[wb_dest] <= wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[mem_addr] <= ex_mem_q.store;
    end

    assign halted = HALTED;

endmodule

// File: tb/tb_pipe_mips32.sv
// Bench for pipe_mips32: directed programs with fixed expectations plus random
// programs checked against an instruction-at-a-time interpreter.
module tb_pipe_mips32;

    localparam int DEPTH = 1024;

    localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_AND = 6'b000010;
    localparam logic [5:0] T_OR = 6'b000011, T_SLT = 6'b000100, T_MUL = 6'b000101;
    localparam logic [5:0] T_LW = 6'b001000, T_SW = 6'b001001, T_ADDI = 6'b001010;
    localparam logic [5:0] T_SUBI = 6'b001011, T_SLTI = 6'b001100;
    localparam logic [5:0] T_BNEQZ = 6'b001101, T_BEQZ = 6'b001110, T_HLT = 6'b111111;
    localparam logic [31:0] FILLER = 32'h0ce77800;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halted;

    pipe_mips32 #(.MEM_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .halted (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int taken_cnt;

    logic [31:0] init_mem [0:DEPTH-1];
    logic [31:0] init_reg [0:31];
    logic [31:0] m_mem    [0:DEPTH-1];
    logic [31:0] m_reg    [0:31];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic clear_init();
        for (int i = 0; i < DEPTH; i++) init_mem[i] = 32'd0;
        for (int k = 0; k < 32; k++) init_reg[k] = 32'(k);
    endtask

    // Hold reset over one edge, preload DUT and model, check reset state, release.
    task automatic load_and_reset(input string name);
        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            dut.mem[i] = init_mem[i];
            m_mem[i]   = init_mem[i];
        end
        for (int k = 0; k < 32; k++) begin
            dut.Reg[k] = init_reg[k];
            m_reg[k]   = init_reg[k];
        end
        check_val({name, "_rst_pc"}, dut.PC, 32'd0);
        check_val({name, "_rst_halted"}, 32'(halted), 32'd0);
        check_val({name, "_rst_taken"}, 32'(dut.TAKEN_BRANCH), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input string name, input int max_cyc, output int cyc);
        cyc = 0;
        taken_cnt = 0;
        while (!halted && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
            if (dut.TAKEN_BRANCH) taken_cnt++;
        end
        check_val({name, "_halted"}, 32'(halted), 32'd1);
        $display("%s: %0d cycles, %0d taken branches", name, cyc, taken_cnt);
    endtask

    // Architectural interpreter: one instruction at a time, no pipeline.
    task automatic run_model();
        logic [31:0] ir, a, b, imm, res;
        logic [5:0]  op;
        int pc, npc, rs, rt, rd, wdest;
        pc = 0;
        for (int step = 0; step < 5000; step++) begin
            ir  = m_mem[pc % DEPTH];
            op  = ir[31:26];
            rs  = int'(ir[25:21]);
            rt  = int'(ir[20:16]);
            rd  = int'(ir[15:11]);
            imm = {{16{ir[15]}}, ir[15:0]};
            a   = m_reg[rs];
            b   = m_reg[rt];
            npc = pc + 1;
            wdest = 0;
            res = 32'd0;
            case (op)
                T_ADD:   begin res = a + b; wdest = rd; end
                T_SUB:   begin res = a - b; wdest = rd; end
                T_AND:   begin res = a & b; wdest = rd; end
                T_OR:    begin res = a | b; wdest = rd; end
                T_SLT:   begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wdest = rd; end
                T_MUL:   begin res = a * b; wdest = rd; end
                T_ADDI:  begin res = a + imm; wdest = rt; end
                T_SUBI:  begin res = a - imm; wdest = rt; end
                T_SLTI:  begin res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; wdest = rt; end
                T_LW:    begin res = m_mem[(a + imm) % 32'(DEPTH)]; wdest = rt; end
                T_SW:    m_mem[(a + imm) % 32'(DEPTH)] = b;
                T_BNEQZ: if (a != 32'd0) npc = pc + 1 + int'(imm);
                T_BEQZ:  if (a == 32'd0) npc = pc + 1 + int'(imm);
                T_HLT:   return;
                default: ;
            endcase
            if (wdest != 0) m_reg[wdest] = res;
            pc = npc;
        end
    endtask

    function automatic logic [5:0] pick_rr();
        case ($urandom_range(0, 5))
            0: return T_ADD;
            1: return T_SUB;
            2: return T_AND;
            3: return T_OR;
            4: return T_SLT;
            default: return T_MUL;
        endcase
    endfunction

    function automatic logic [5:0] pick_ri();
        case ($urandom_range(0, 2))
            0: return T_ADDI;
            1: return T_SUBI;
            default: return T_SLTI;
        endcase
    endfunction

    // R31 is a fixed data base (600); random code never writes it, so data stays clear of code.
    task automatic gen_random();
        int i, kind;
        logic [5:0] op;
        clear_init();
        for (int k = 1; k < 32; k++) init_reg[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        for (int j = 500; j <= 700; j++) init_mem[j] = $urandom;
        init_mem[0] = enc_i(T_ADDI, 31, 0, 600);
        i = 1;
        while (i <= 40) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 4) begin
                init_mem[i] = enc_i(pick_ri(), int'($urandom_range(0, 30)), int'($urandom_range(0, 31)),
                                    int'($urandom_range(0, 65535)));
            end else if (kind == 5 && i < 40) begin
                init_mem[i] = enc_i(T_LW, int'($urandom_range(1, 30)), 31, int'($urandom_range(0, 100)) - 50);
                i++;
                init_mem[i] = enc_i(T_ADDI, int'($urandom_range(1, 30)), 0, int'($urandom_range(0, 65535)));
            end else if (kind == 6) begin
                init_mem[i] = enc_i(T_SW, int'($urandom_range(0, 31)), 31, int'($urandom_range(0, 100)) - 50);
            end else if (kind == 7) begin
                op = ($urandom_range(0, 1) == 0) ? T_BEQZ : T_BNEQZ;
                init_mem[i] = enc_i(op, 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
            end else if (kind == 8) begin
                init_mem[i] = {6'b010000, 26'($urandom)};
            end else begin
                init_mem[i] = enc_r(pick_rr(), int'($urandom_range(0, 30)), int'($urandom_range(0, 31)),
                                    int'($urandom_range(0, 31)));
            end
            i++;
        end
        for (int j = 41; j < 49; j++) init_mem[j] = {T_HLT, 26'd0};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Program completion with fillers
        clear_init();
        init_mem[0] = 32'h2801000a;
        init_mem[1] = enc_i(T_ADDI, 2, 0, 20);
        init_mem[2] = enc_i(T_ADDI, 3, 0, 25);
        init_mem[3] = FILLER;
        init_mem[4] = FILLER;
        init_mem[5] = 32'h00222000;
        init_mem[6] = FILLER;
        init_mem[7] = 32'h00832800;
        init_mem[8] = 32'hfc000000;
        load_and_reset("prog");
        run_to_halt("prog", 40, cyc);
        check_val("prog_cycles_le_13", 32'(cyc <= 13), 32'd1);
        check_val("prog_r0", dut.Reg[0], 32'd0);
        check_val("prog_r1", dut.Reg[1], 32'd10);
        check_val("prog_r2", dut.Reg[2], 32'd20);
        check_val("prog_r3", dut.Reg[3], 32'd25);
        check_val("prog_r4", dut.Reg[4], 32'd30);
        check_val("prog_r5", dut.Reg[5], 32'd55);

        // Back-to-back RAW through forwarding
        clear_init();
        init_mem[0] = enc_i(T_ADDI, 1, 0, 7);
        init_mem[1] = enc_r(T_ADD, 2, 1, 1);
        init_mem[2] = enc_r(T_ADD, 3, 2, 1);
        init_mem[3] = {T_HLT, 26'd0};
        load_and_reset("raw");
        run_to_halt("raw", 40, cyc);
        check_val("raw_r2", dut.Reg[2], 32'd14);
        check_val("raw_r3", dut.Reg[3], 32'd21);

        // Load, filler, use, store
        clear_init();
        init_reg[1]   = 32'd120;
        init_mem[120] = 32'd85;
        init_mem[0] = enc_i(T_LW, 2, 1, 0);
        init_mem[1] = FILLER;
        init_mem[2] = enc_i(T_ADDI, 2, 2, 45);
        init_mem[3] = enc_i(T_SW, 2, 1, 1);
        init_mem[4] = {T_HLT, 26'd0};
        load_and_reset("ldst");
        run_to_halt("ldst", 40, cyc);
        check_val("ldst_mem121", dut.mem[121], 32'd130);
        check_val("ldst_r2", dut.Reg[2], 32'd130);

        // Factorial loop; the two wrong-path increments commit only on loop exit
        clear_init();
        init_reg[10] = 32'd7;
        init_mem[0] = enc_i(T_ADDI, 2, 0, 1);
        init_mem[1] = enc_r(T_MUL, 2, 2, 10);
        init_mem[2] = enc_i(T_SUBI, 10, 10, 1);
        init_mem[3] = enc_i(T_BNEQZ, 0, 10, -3);
        init_mem[4] = enc_i(T_ADDI, 11, 11, 1);
        init_mem[5] = enc_i(T_ADDI, 12, 12, 1);
        init_mem[6] = {T_HLT, 26'd0};
        load_and_reset("fact");
        run_to_halt("fact", 200, cyc);
        check_val("fact_r2", dut.Reg[2], 32'd5040);
        check_val("fact_r10", dut.Reg[10], 32'd0);
        check_val("fact_r11", dut.Reg[11], 32'd12);
        check_val("fact_r12", dut.Reg[12], 32'd13);
        check_val("fact_taken", 32'(taken_cnt), 32'd6);

        // HLT squashes younger instructions and freezes the machine
        clear_init();
        init_mem[0] = enc_i(T_ADDI, 1, 0, 5);
        init_mem[1] = {T_HLT, 26'd0};
        init_mem[2] = enc_i(T_ADDI, 9, 0, 99);
        init_mem[3] = enc_i(T_ADDI, 8, 0, 77);
        load_and_reset("hlt");
        run_to_halt("hlt", 40, cyc);
        check_val("hlt_pc", dut.PC, 32'd2);
        repeat (8) @(posedge clk);
        #1;
        check_val("hlt_pc_frozen", dut.PC, 32'd2);
        check_val("hlt_port", 32'(halted), 32'd1);
        check_val("hlt_r9", dut.Reg[9], 32'd9);
        check_val("hlt_r8", dut.Reg[8], 32'd8);
        check_val("hlt_r1", dut.Reg[1], 32'd5);

        // Mid-program reset discards in-flight work, then the program reruns
        clear_init();
        init_mem[0] = enc_i(T_ADDI, 20, 20, 1);
        init_mem[1] = enc_i(T_ADDI, 21, 21, 1);
        init_mem[2] = enc_i(T_ADDI, 22, 22, 1);
        init_mem[3] = enc_i(T_ADDI, 23, 23, 1);
        init_mem[4] = {T_HLT, 26'd0};
        load_and_reset("mrst");
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("mrst_pc", dut.PC, 32'd0);
        check_val("mrst_halted", 32'(halted), 32'd0);
        check_val("mrst_r20_nowrite", dut.Reg[20], 32'd20);
        @(negedge clk);
        rst_n = 1'b1;
        run_to_halt("mrst", 40, cyc);
        check_val("mrst_r20", dut.Reg[20], 32'd21);
        check_val("mrst_r21", dut.Reg[21], 32'd22);
        check_val("mrst_r22", dut.Reg[22], 32'd23);
        check_val("mrst_r23", dut.Reg[23], 32'd24);

        // Random programs against the interpreter
        for (int t = 0; t < 6; t++) begin
            gen_random();
            load_and_reset($sformatf("rnd%0d", t));
            run_model();
            run_to_halt($sformatf("rnd%0d", t), 600, cyc);
            for (int k = 0; k < 32; k++)
                check_val($sformatf("rnd%0d_r%0d", t, k), dut.Reg[k], m_reg[k]);
            for (int j = 500; j <= 700; j++)
                check_val($sformatf("rnd%0d_mem%0d", t, j), dut.mem[j], m_mem[j]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
